// File: rtl/burst_ram.sv
// burst_ram: word-addressed backing memory with single/wrapping-burst access and programmable latency
module burst_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int BYTE_OFFSET = 2,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_burst,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_last,
    output logic                    done,
    output logic                    busy
);
    localparam int IW = ADDR_WIDTH - BYTE_OFFSET;
    localparam int BW = $clog2(BLOCK_WORDS);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAT_LAST  = CW'(LATENCY - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, READ} state_t;

    state_t                state;
    logic                  wr;
    logic                  burst;
    logic [IW-1:0]         base;
    logic [BW-1:0]         beat;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] mem [2**IW];
    logic [IW-1:0]         idx;
    logic                  last_beat;

    assign idx       = burst ? {base[IW-1:BW], base[BW-1:0] + beat} : base;
    assign last_beat = !burst || beat == BEAT_LAST;
    assign req_ready = rst_n && !busy;

    always_ff @(posedge clk)
        if (rst_n && state == WRITE && wdata_valid && wdata_ready)
            for (int i = 0; i < NB; i++)
                if (wbe[i])
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr          <= 1'b0;
            burst       <= 1'b0;
            base        <= '0;
            beat        <= '0;
            cnt         <= '0;
            wdata_ready <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_last    <= 1'b0;
            rsp_rdata   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    wr    <= req_write;
                    burst <= req_burst;
                    base  <= IW'(req_addr >> BYTE_OFFSET);
                    beat  <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= WAIT;
                end
                WAIT: if (cnt == LAT_LAST) begin
                    state       <= wr ? WRITE : READ;
                    wdata_ready <= wr;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                WRITE: if (wdata_valid) begin
                    beat <= beat + 1'b1;
                    if (last_beat) begin
                        state       <= IDLE;
                        wdata_ready <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                READ: if (rsp_valid && rsp_ready && rsp_last) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_last  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end else if (!rsp_valid || rsp_ready) begin
                    rsp_rdata <= mem[idx];
                    rsp_valid <= 1'b1;
                    rsp_last  <= last_beat;
                    beat      <= beat + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram: vector table plus read-beat scoreboard for burst_ram
module tb_burst_ram;
    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_write = 0, req_burst = 0;
    logic [15:0] req_addr = '0;
    logic        wdata_valid = 0, rsp_ready = 1;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;
    logic        req_ready, wdata_ready, rsp_valid, rsp_last, done, busy;
    logic [31:0] rsp_rdata;
    int          checks = 0, errors = 0;

    typedef struct {
        logic        wr;
        logic        b;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] dat [4];
        logic [31:0] exp [4];
    } vec_t;
    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    vec_t  vecs [11];

    always #5 clk = ~clk;

    burst_ram dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_burst(req_burst), .req_addr(req_addr),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wbe(wbe),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
        .done(done), .busy(busy)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic b, input logic [15:0] a, input logic [3:0] be,
                                input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        vec_t v;
        v.wr = wr; v.b = b; v.addr = a; v.be = be;
        v.dat[0] = w0; v.dat[1] = w1; v.dat[2] = w2; v.dat[3] = w3;
        v.exp = v.dat;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_beat: got %h, required no beat", rsp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdata", rsp_rdata, mon_e.d);
                chk("rlast", 32'(rsp_last), 32'(mon_e.l));
            end
        end
    end

    task automatic push_exp(input vec_t v);
        beat_t e;
        int n;
        n = v.b ? 4 : 1;
        for (int b = 0; b < n; b++) begin
            e.d = v.exp[b];
            e.l = (b == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_req(input logic wr, input logic b, input logic [15:0] a);
        int k;
        req_valid = 1; req_write = wr; req_burst = b; req_addr = a;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (k == 50) begin
            checks++;
            errors++;
            $display("FAIL req_accept: got no req_ready in 50 cycles, required accept");
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic send_beats(input vec_t v, input int gap);
        int n, k;
        n = v.b ? 4 : 1;
        for (int b = 0; b < n; b++) begin
            wdata_valid = 1; wdata = v.dat[b]; wbe = v.be;
            for (k = 0; k < 50; k++) begin
                @(negedge clk);
                if (wdata_ready) break;
            end
            chk("wdata_ready", 32'(wdata_ready), 1);
            @(posedge clk); #1;
            wdata_valid = 0;
            if (b < n - 1)
                repeat (gap) begin
                    @(negedge clk);
                    chk("wready_stall", 32'(wdata_ready), 1);
                    @(posedge clk); #1;
                end
        end
    endtask

    task automatic wait_done(input string n);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({n, "_done"}, 32'(done), 1);
        chk({n, "_rdy"}, 32'(req_ready), 1);
        chk({n, "_busy"}, 32'(busy), 0);
        @(negedge clk);
        chk({n, "_pulse"}, 32'(done), 0);
        @(posedge clk); #1;
    endtask

    task automatic run(input vec_t v, input int gap, input string n);
        if (!v.wr) push_exp(v);
        start_req(v.wr, v.b, v.addr);
        if (v.wr) send_beats(v, gap);
        wait_done(n);
        if (!v.wr) chk({n, "_beats"}, 32'(exp_q.size()), 0);
    endtask

    task automatic wait_first_hs();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) break;
        end
    endtask

    localparam logic [31:0] A0 = 32'hA0A0A0A0, A1 = 32'hA1A1A1A1, A2 = 32'hA2A2A2A2, A3 = 32'hA3A3A3A3;
    localparam logic [31:0] B0 = 32'hB0B0B0B0, B1 = 32'hB1B1B1B1, B2 = 32'hB2B2B2B2, B3 = 32'hB3B3B3B3;
    localparam logic [31:0] D0 = 32'hD0000000, D1 = 32'hD1111111, D2 = 32'hD2222222, D3 = 32'hD3333333;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        int lat;
        vecs[0]  = mk(1, 0, 16'h0010, 4'hF, 32'hDEADBEEF, 0, 0, 0);
        vecs[1]  = mk(0, 0, 16'h0010, 4'h0, 32'hDEADBEEF, 0, 0, 0);
        vecs[2]  = mk(1, 0, 16'h0010, 4'b0101, 32'h11223344, 0, 0, 0);
        vecs[3]  = mk(0, 0, 16'h0010, 4'h0, 32'hDE22BE44, 0, 0, 0);
        vecs[4]  = mk(1, 1, 16'h0020, 4'hF, A0, A1, A2, A3);
        vecs[5]  = mk(0, 1, 16'h0028, 4'h0, A2, A3, A0, A1);
        vecs[6]  = mk(1, 1, 16'h0034, 4'hF, B0, B1, B2, B3);
        vecs[7]  = mk(0, 1, 16'h0030, 4'h0, B3, B0, B1, B2);
        vecs[8]  = mk(1, 0, 16'h0038, 4'b1010, 32'h12345678, 0, 0, 0);
        vecs[9]  = mk(0, 1, 16'h003C, 4'h0, B2, B3, B0, 32'h12B156B1);
        vecs[10] = mk(0, 0, 16'h0022, 4'h0, A0, 0, 0, 0);

        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_wdata_ready", 32'(wdata_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rsp_last", 32'(rsp_last), 0);
        chk("rst_rdata", rsp_rdata, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run(vecs[i], 0, $sformatf("vec%0d", i));

        push_exp(vecs[3]);
        start_req(0, 0, 16'h0010);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 3);
        wait_done("lat");

        wdata_valid = 1; wdata = 32'hBAD0BAD0; wbe = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("stray_wready", 32'(wdata_ready), 0);
            @(posedge clk); #1;
        end
        wdata_valid = 0;
        run(vecs[3], 0, "stray_rd");

        run(mk(1, 1, 16'h0040, 4'hF, D0, D1, D2, D3), 2, "wgap");
        push_exp(mk(0, 1, 16'h0040, 4'h0, D0, D1, D2, D3));
        start_req(0, 1, 16'h0040);
        wait_first_hs();
        @(posedge clk); #1;
        rsp_ready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", rsp_rdata, D1);
            chk("hold_last", 32'(rsp_last), 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        wait_done("stall");
        chk("stall_beats", 32'(exp_q.size()), 0);

        push_exp(mk(0, 1, 16'h0020, 4'h0, A0, A1, A2, A3));
        start_req(0, 1, 16'h0020);
        wait_first_hs();
        @(posedge clk); #1;
        rst_n = 0; rsp_ready = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_req_ready", 32'(req_ready), 0);
        chk("abort_left", 32'(exp_q.size()), 3);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1; rsp_ready = 1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
            @(posedge clk); #1;
        end
        run(vecs[5], 0, "post_rst_a");
        run(mk(0, 1, 16'h0044, 4'h0, D1, D2, D3, D0), 0, "post_rst_d");

        push_exp(vecs[3]);
        push_exp(vecs[10]);
        start_req(0, 0, 16'h0010);
        req_valid = 1; req_write = 0; req_burst = 0; req_addr = 16'h0020;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) break;
            chk("held_ready", 32'(req_ready), 0);
        end
        chk("held_done", 32'(done), 1);
        chk("held_done_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        chk("held_accepted", 32'(busy), 1);
        wait_done("held2");
        chk("held_beats", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
